// File: rtl/coef_rx_8a12.sv
// coef_rx_8a12 -- UART byte-pair to FIR coefficient loader.
//
// Two UART bytes arrive low byte first. Each pair is packed into one unsigned
// COEF_W-bit coefficient, coef = {hi[3:0], lo[7:0]}. Packed coefficients are
// written in order into a bank of N_COEF registers. A load is armed by
// en_recepcion_i. The FIR reads the bank through a registered port.
//
// Ports:
//   clk_i             system clock, rising edge
//   rst_i             asynchronous reset, active-high
//   en_recepcion_i    load enable from the control block
//   rx_data_i         UART byte
//   rx_valid_i        one strobe per byte (one byte per high cycle)
//   coef_idx_i        FIR read address
//   coef_o            bank[coef_idx_i], one cycle latency
//   c_listo_o         one-cycle pulse per stored coefficient
//   fin_block_coef_o  level, all N_COEF coefficients loaded
//   count_o           coefficients written in the current load
//   err_o             sticky, a high byte carried nonzero bits above the data
module coef_rx_8a12 #(
  parameter int N_COEF = 16,
  parameter int COEF_W = 12,
  parameter int BYTE_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_recepcion_i,
  input  logic [BYTE_W-1:0] rx_data_i,
  input  logic              rx_valid_i,
  input  logic [3:0]        coef_idx_i,
  output logic [COEF_W-1:0] coef_o,
  output logic              c_listo_o,
  output logic              fin_block_coef_o,
  output logic [4:0]        count_o,
  output logic              err_o
);

  localparam int         IDX_W  = (N_COEF > 1) ? $clog2(N_COEF) : 1;
  localparam int         HI_W   = COEF_W - BYTE_W;
  localparam logic [4:0] N_LAST = 5'(N_COEF);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  state_t              state, state_nxt;
  logic [BYTE_W-1:0]   lo_byte;
  logic [COEF_W-1:0]   bank [N_COEF];
  logic [4:0]          count_inc;

  logic load_start, abort, lo_cap, wr, wr_last;

  function automatic logic [COEF_W-1:0] pack_coef(input logic [BYTE_W-1:0] hi,
                                                  input logic [BYTE_W-1:0] lo);
    return {hi[HI_W-1:0], lo};
  endfunction

  // Bits of the high byte that carry no coefficient data must be zero.
  function automatic logic hi_bad(input logic [BYTE_W-1:0] hi);
    return |hi[BYTE_W-1:HI_W];
  endfunction

  assign count_inc  = count_o + 5'd1;
  assign load_start = (state == IDLE) && en_recepcion_i;
  // Dropping the enable mid-load beats a byte arriving in the same cycle.
  assign abort      = ((state == LOW) || (state == HIGH)) && !en_recepcion_i;
  assign lo_cap     = (state == LOW)  && en_recepcion_i && rx_valid_i;
  assign wr         = (state == HIGH) && en_recepcion_i && rx_valid_i;
  assign wr_last    = wr && (count_inc == N_LAST);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (en_recepcion_i) state_nxt = LOW;
      LOW: begin
        if (!en_recepcion_i) state_nxt = IDLE;
        else if (rx_valid_i) state_nxt = HIGH;
      end
      HIGH: begin
        if (!en_recepcion_i) state_nxt = IDLE;
        else if (rx_valid_i) state_nxt = wr_last ? DONE : LOW;
      end
      DONE: if (!en_recepcion_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lo_byte          <= '0;
      count_o          <= '0;
      fin_block_coef_o <= 1'b0;
      err_o            <= 1'b0;
      c_listo_o        <= 1'b0;
      coef_o           <= '0;
      for (int i = 0; i < N_COEF; i++) bank[i] <= '0;
    end else begin
      c_listo_o <= wr;
      // Read sees the bank before any write in the same cycle.
      coef_o    <= bank[coef_idx_i[IDX_W-1:0]];
      if (load_start) begin
        count_o          <= '0;
        fin_block_coef_o <= 1'b0;
        err_o            <= 1'b0;
      end
      if (abort) begin
        count_o <= '0;
        lo_byte <= '0;
      end
      if (lo_cap) lo_byte <= rx_data_i;
      if (wr) begin
        bank[count_o[IDX_W-1:0]] <= pack_coef(rx_data_i, lo_byte);
        count_o                  <= count_inc;
        if (hi_bad(rx_data_i)) err_o <= 1'b1;
        if (wr_last) fin_block_coef_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_coef_rx_8a12.sv
// Testbench for coef_rx_8a12: directed load/abort/error/reset scenarios plus a
// randomized phase, all compared cycle by cycle against a byte-counting model.
module tb_coef_rx_8a12;

  localparam int NC = 16;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        en;
  logic [7:0]  data;
  logic        vld;
  logic [3:0]  idx;
  logic [11:0] coef_o;
  logic        c_listo_o;
  logic        fin_block_coef_o;
  logic [4:0]  count_o;
  logic        err_o;

  int checks   = 0;
  int failures = 0;

  // Reference model: a load is a stream of accepted bytes; the coefficient
  // count is half the bytes seen, and every second byte completes an entry.
  bit          m_active;
  int          m_nbytes;
  logic [7:0]  m_lo;
  logic [11:0] m_bank [NC];
  bit          m_fin, m_err;
  bit          exp_listo;
  logic [11:0] exp_coef;

  coef_rx_8a12 dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .en_recepcion_i   (en),
    .rx_data_i        (data),
    .rx_valid_i       (vld),
    .coef_idx_i       (idx),
    .coef_o           (coef_o),
    .c_listo_o        (c_listo_o),
    .fin_block_coef_o (fin_block_coef_o),
    .count_o          (count_o),
    .err_o            (err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_active  = 0;
    m_nbytes  = 0;
    m_lo      = '0;
    m_fin     = 0;
    m_err     = 0;
    exp_listo = 0;
    exp_coef  = '0;
    for (int i = 0; i < NC; i++) m_bank[i] = '0;
  endtask

  task automatic model_edge();
    exp_coef  = m_bank[idx];
    exp_listo = 0;
    if (!m_active) begin
      if (en) begin
        m_active = 1;
        m_nbytes = 0;
        m_fin    = 0;
        m_err    = 0;
      end
    end else if (!en) begin
      m_active = 0;
      if (m_nbytes < 2*NC) m_nbytes = 0;
    end else if (vld && m_nbytes < 2*NC) begin
      if (m_nbytes % 2 == 0) m_lo = data;
      else begin
        m_bank[m_nbytes/2] = {data[3:0], m_lo};
        if (data[7:4] != 4'h0) m_err = 1;
        exp_listo = 1;
      end
      m_nbytes++;
      if (m_nbytes == 2*NC) m_fin = 1;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk_i);
    #1;
    check("c_listo", 32'(c_listo_o), 32'(exp_listo));
    check("fin", 32'(fin_block_coef_o), 32'(m_fin));
    check("count", 32'(count_o), 32'(m_nbytes / 2));
    check("err", 32'(err_o), 32'(m_err));
    check("coef", 32'(coef_o), 32'(exp_coef));
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    vld  = 1'b1;
    data = b;
    tick();
    vld  = 1'b0;
    for (int g = 1; g < gap; g++) tick();
  endtask

  task automatic restart();
    en = 1'b0; tick();
    en = 1'b1; tick();
  endtask

  initial begin
    rst_i = 1'b1; en = 1'b0; vld = 1'b0; data = '0; idx = '0;
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_coef", 32'(coef_o), 32'h0);
    check("rst_listo", 32'(c_listo_o), 32'h0);
    check("rst_fin", 32'(fin_block_coef_o), 32'h0);
    check("rst_count", 32'(count_o), 32'h0);
    check("rst_err", 32'(err_o), 32'h0);
    rst_i = 1'b0;

    // Full load, lo=k hi=0x0k, one byte every 4 clocks.
    en = 1'b1; tick();
    for (int k = 0; k < NC; k++) begin
      send_byte(8'(k), 4);
      send_byte(8'(k), 4);
    end
    check("load1_fin", 32'(fin_block_coef_o), 32'h1);
    check("load1_count", 32'(count_o), 32'd16);
    idx = 4'd5; tick();
    check("load1_coef5", 32'(coef_o), 32'h505);

    // Bytes after completion are ignored.
    for (int k = 0; k < 4; k++) send_byte(8'($urandom), 2);
    idx = 4'd15; tick();
    check("done_frozen15", 32'(coef_o), 32'hF0F);
    check("done_fin", 32'(fin_block_coef_o), 32'h1);

    // fin holds through IDLE and clears at the next load start.
    en = 1'b0; tick(); tick();
    check("idle_fin_hold", 32'(fin_block_coef_o), 32'h1);
    en = 1'b1; tick();
    check("start_fin_clr", 32'(fin_block_coef_o), 32'h0);
    for (int k = 0; k < NC; k++) begin
      send_byte(8'hFF, 2);
      send_byte(8'h0F, 2);
    end
    check("fff_fin", 32'(fin_block_coef_o), 32'h1);
    for (int i = 0; i < NC; i++) begin
      idx = 4'(i); tick();
      check("bank_fff", 32'(coef_o), 32'hFFF);
    end

    // Abort after 7 coefficients and a low byte; back-to-back strobes.
    restart();
    for (int k = 0; k < 14; k++) send_byte(8'($urandom) & 8'h0F, 1);
    send_byte(8'h77, 1);
    en = 1'b0; vld = 1'b1; data = 8'h01; tick();
    vld = 1'b0;
    check("abort_count", 32'(count_o), 32'h0);
    check("abort_fin", 32'(fin_block_coef_o), 32'h0);
    tick();
    check("abort_no_pulse", 32'(c_listo_o), 32'h0);

    // Fresh load starts at index 0; bad high nibble raises err.
    en = 1'b1; tick();
    send_byte(8'h21, 2);
    send_byte(8'hA3, 2);
    idx = 4'd0; tick();
    check("err_coef", 32'(coef_o), 32'h321);
    check("err_set", 32'(err_o), 32'h1);
    check("err_count", 32'(count_o), 32'h1);
    tick(); tick();
    check("err_sticky", 32'(err_o), 32'h1);
    restart();
    check("err_clr", 32'(err_o), 32'h0);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      if (en) begin
        if ($urandom_range(0, 99) < 3) en = 1'b0;
      end else if ($urandom_range(0, 99) < 30) en = 1'b1;
      vld  = ($urandom_range(0, 99) < 45);
      data = 8'($urandom);
      if ($urandom_range(0, 3) != 0) data[7:4] = 4'h0;
      idx  = 4'($urandom);
      tick();
    end

    // Asynchronous reset between clock edges in the middle of a load.
    vld = 1'b0; restart();
    for (int k = 0; k < 5; k++) send_byte(8'($urandom), 2);
    #3 rst_i = 1'b1;
    #1;
    check("arst_coef", 32'(coef_o), 32'h0);
    check("arst_listo", 32'(c_listo_o), 32'h0);
    check("arst_fin", 32'(fin_block_coef_o), 32'h0);
    check("arst_count", 32'(count_o), 32'h0);
    check("arst_err", 32'(err_o), 32'h0);
    model_reset();
    en = 1'b0;
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    for (int i = 0; i < NC; i++) begin
      idx = 4'(i); tick();
      check("arst_bank", 32'(coef_o), 32'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
